// File: rtl/wb_switch_n_if.sv
// Wishbone classic bundle for wb_switch_n: the master-side port plus the fan-out to NSLAVE slaves.
// The master modport is the environment (bus master and external slaves); the slave modport is the switch.
interface wb_switch_n_if #(
   parameter int NSLAVE = 4,
   parameter int AW     = 32,
   parameter int DW     = 32
);
   localparam int SW = DW / 8;

   logic [AW-1:0]        m_adr_i;
   logic [DW-1:0]        m_dat_i;
   logic [DW-1:0]        m_dat_o;
   logic [SW-1:0]        m_sel_i;
   logic                 m_we_i;
   logic                 m_cyc_i;
   logic                 m_stb_i;
   logic                 m_ack_o;
   logic                 m_err_o;

   logic [AW-1:0]        s_adr_o;
   logic [DW-1:0]        s_dat_o;
   logic [SW-1:0]        s_sel_o;
   logic                 s_we_o;
   logic [NSLAVE-1:0]    s_cyc_o;
   logic [NSLAVE-1:0]    s_stb_o;
   logic [NSLAVE*DW-1:0] s_dat_i;
   logic [NSLAVE-1:0]    s_ack_i;
   logic [NSLAVE-1:0]    s_err_i;

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );
endinterface

// File: rtl/wb_switch_n.sv
// Wishbone classic 1-to-NSLAVE switch with a built-in default slave, registered slave select,
// bus-timeout watchdog and fault-address capture.
module wb_switch_n #(
   parameter int                   NSLAVE   = 4,
   parameter int                   AW       = 32,
   parameter int                   DW       = 32,
   parameter logic [NSLAVE*AW-1:0] ADDR_MAP = '0,
   parameter logic [NSLAVE*AW-1:0] MASK_MAP = '0,
   parameter int                   TIMEOUT  = 255,
   parameter logic [DW-1:0]        DEF_DATA = {(DW/8){8'haa}},
   parameter bit                   DEF_ERR  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   wb_switch_n_if.slave  bus,
   output logic          fault_o,
   output logic [AW-1:0] fault_adr_o
);
   localparam int            IW    = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
   localparam int            TW    = 16;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [IW-1:0] sel_idx;
   logic          def_sel;
   logic [TW-1:0] timer;

   logic [IW-1:0] dec_idx;
   logic          dec_hit;
   logic          slv_ack;
   logic          slv_err;
   logic [DW-1:0] slv_dat;
   logic          tmo;

   assign bus.s_adr_o = bus.m_adr_i;
   assign bus.s_dat_o = bus.m_dat_i;
   assign bus.s_sel_o = bus.m_sel_i;
   assign bus.s_we_o  = bus.m_we_i;

   // Scan from the top index down so the lowest matching window overwrites the rest.
   always_comb begin : decode
      dec_idx = '0;
      dec_hit = 1'b0;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if ((bus.m_adr_i & MASK_MAP[i*AW +: AW]) == (ADDR_MAP[i*AW +: AW] & MASK_MAP[i*AW +: AW])) begin
            dec_idx = IW'(i);
            dec_hit = 1'b1;
         end
      end
   end

   always_comb begin : slave_mux
      slv_ack = 1'b0;
      slv_err = 1'b0;
      slv_dat = '0;
      for (int i = 0; i < NSLAVE; i++) begin
         if (sel_idx == IW'(i)) begin
            slv_ack = bus.s_ack_i[i];
            slv_err = bus.s_err_i[i];
            slv_dat = bus.s_dat_i[i*DW +: DW];
         end
      end
   end

   assign tmo = !slv_ack && !slv_err && (timer == TLAST);

   // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
   always_comb begin : respond
      bus.s_cyc_o = '0;
      bus.s_stb_o = '0;
      bus.m_ack_o = 1'b0;
      bus.m_err_o = 1'b0;
      bus.m_dat_o = '0;
      fault_o     = 1'b0;
      if (state == BUSY) begin
         if (def_sel) begin
            bus.m_dat_o = DEF_DATA;
            if (bus.m_cyc_i) begin
               bus.m_ack_o = !DEF_ERR;
               bus.m_err_o = DEF_ERR;
               fault_o     = DEF_ERR;
            end
         end else begin
            bus.m_dat_o = slv_dat;
            bus.s_cyc_o = NSLAVE'(bus.m_cyc_i) << sel_idx;
            bus.s_stb_o = NSLAVE'(bus.m_cyc_i & bus.m_stb_i) << sel_idx;
            if (bus.m_cyc_i) begin
               // err wins over a simultaneous ack
               bus.m_ack_o = slv_ack && !slv_err;
               bus.m_err_o = slv_err || tmo;
               fault_o     = tmo;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         sel_idx     <= '0;
         def_sel     <= 1'b0;
         timer       <= '0;
         fault_adr_o <= '0;
      end else begin
         if (fault_o) begin
            fault_adr_o <= bus.s_adr_o;
         end
         case (state)
            IDLE: begin
               if (bus.m_cyc_i && bus.m_stb_i) begin
                  state   <= BUSY;
                  sel_idx <= dec_hit ? dec_idx : '0;
                  def_sel <= !dec_hit;
                  timer   <= '0;
               end
            end
            BUSY: begin
               if (!bus.m_cyc_i || bus.m_ack_o || bus.m_err_o) begin
                  state <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_switch_n.sv
// Self-checking bench for wb_switch_n: ROM/TUBE/RAM map, default slave in both flavours,
// timeout, err-over-ack, master abort, reset while busy and back-to-back transfers.
module tb_wb_switch_n;
   localparam int NS  = 3;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   localparam logic [NS*AW-1:0] ADDR_MAP = {32'h0000_0000, 32'h0100_0000, 32'h0000_0000};
   localparam logic [NS*AW-1:0] MASK_MAP = {32'h03E0_0000, 32'h0300_0000, 32'h03FF_FFFC};

   localparam logic [DW-1:0] ROM_DAT  = 32'hDEAD_BEEF;
   localparam logic [DW-1:0] TUBE_DAT = 32'h7B7B_0001;
   localparam logic [DW-1:0] RAM_DAT  = 32'h5A5A_0002;
   localparam logic [DW-1:0] DEF_DAT  = 32'hAAAA_AAAA;

   typedef struct {
      logic          ack;
      logic          err;
      logic [DW-1:0] dat;
      logic          fault;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   logic          fault0, fault1;
   logic [AW-1:0] fadr0, fadr1;

   logic       ram_stall;
   logic       tube_errmode;
   logic [1:0] tube_cnt;
   logic       tube_hit;

   always #5 clk = ~clk;

   wb_switch_n_if #(.NSLAVE(NS), .AW(AW), .DW(DW)) bus ();
   wb_switch_n_if #(.NSLAVE(NS), .AW(AW), .DW(DW)) bus1 ();

   wb_switch_n #(
      .NSLAVE(NS), .AW(AW), .DW(DW), .ADDR_MAP(ADDR_MAP), .MASK_MAP(MASK_MAP),
      .TIMEOUT(TMO), .DEF_DATA(DEF_DAT), .DEF_ERR(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .fault_o(fault0), .fault_adr_o(fadr0)
   );

   // Second switch with an erroring default slave; it shadows the same master and has silent slaves.
   wb_switch_n #(
      .NSLAVE(NS), .AW(AW), .DW(DW), .ADDR_MAP(ADDR_MAP), .MASK_MAP(MASK_MAP),
      .TIMEOUT(TMO), .DEF_DATA(DEF_DAT), .DEF_ERR(1'b1)
   ) dut_err (
      .clk(clk), .rst(rst), .bus(bus1), .fault_o(fault1), .fault_adr_o(fadr1)
   );

   assign bus1.m_adr_i = bus.m_adr_i;
   assign bus1.m_dat_i = bus.m_dat_i;
   assign bus1.m_sel_i = bus.m_sel_i;
   assign bus1.m_we_i  = bus.m_we_i;
   assign bus1.m_cyc_i = bus.m_cyc_i;
   assign bus1.m_stb_i = bus.m_stb_i;
   assign bus1.s_dat_i = '0;
   assign bus1.s_ack_i = '0;
   assign bus1.s_err_i = '0;

   // Slave models: ROM zero-wait, TUBE zero-wait or err+ack on its 3rd strobe cycle, RAM zero-wait or stalled.
   always_ff @(posedge clk) begin
      if (rst || !bus.s_stb_o[1]) tube_cnt <= 2'd0;
      else if (tube_cnt != 2'd3)  tube_cnt <= tube_cnt + 2'd1;
   end
   assign tube_hit    = bus.s_stb_o[1] && (!tube_errmode || tube_cnt == 2'd2);
   assign bus.s_dat_i = {RAM_DAT, TUBE_DAT, ROM_DAT};
   assign bus.s_ack_i = {bus.s_stb_o[2] && !ram_stall, tube_hit, bus.s_stb_o[0]};
   assign bus.s_err_i = {1'b0, tube_hit && tube_errmode, 1'b0};

   task automatic xfer(input string name, input logic [AW-1:0] adr, input logic we, input logic [SW-1:0] sel,
                       input logic [DW-1:0] wdat, input int stb_bit, input logic e_ack, input logic e_err,
                       input logic [DW-1:0] e_dat, input logic e_fault, input int e_lat,
                       input bit keep, input bit alt);
      exp_t          e;
      bit            done;
      logic [NS-1:0] exp_stb;
      done    = 1'b0;
      exp_stb = (stb_bit >= 0) ? (NS'(1) << stb_bit) : '0;
      e.ack = e_ack; e.err = e_err; e.dat = e_dat; e.fault = e_fault; e.lat = e_lat;
      sb.push_back(e);
      @(posedge clk); #1;
      bus.m_adr_i = adr; bus.m_we_i = we; bus.m_sel_i = sel; bus.m_dat_i = wdat;
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      for (int n = 1; n <= 40 && !done; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++;
            if (bus.s_stb_o !== '0) begin
               errors++; $display("FAIL %s idle_strobe: got %b want 000", name, bus.s_stb_o);
            end
            checks++;
            if (bus.s_adr_o !== adr || bus.s_we_o !== we || bus.s_sel_o !== sel || bus.s_dat_o !== wdat) begin
               errors++;
               $display("FAIL %s broadcast: got adr=%h we=%b sel=%b dat=%h want adr=%h we=%b sel=%b dat=%h",
                        name, bus.s_adr_o, bus.s_we_o, bus.s_sel_o, bus.s_dat_o, adr, we, sel, wdat);
            end
         end else begin
            checks++;
            if (bus.s_stb_o !== exp_stb || bus.s_cyc_o !== exp_stb) begin
               errors++;
               $display("FAIL %s strobe(cyc %0d): got stb=%b cyc=%b want %b", name, n, bus.s_stb_o, bus.s_cyc_o, exp_stb);
            end
         end
         if (bus.m_ack_o === 1'b1 || bus.m_err_o === 1'b1) begin
            done = 1'b1;
            e = sb.pop_front();
            checks++;
            if (n != e.lat) begin
               errors++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
            end
            checks++;
            if (bus.m_ack_o !== e.ack || bus.m_err_o !== e.err) begin
               errors++;
               $display("FAIL %s response: got ack=%b err=%b want ack=%b err=%b", name, bus.m_ack_o, bus.m_err_o, e.ack, e.err);
            end
            if (e.ack) begin
               checks++;
               if (bus.m_dat_o !== e.dat) begin
                  errors++; $display("FAIL %s rdata: got %h want %h", name, bus.m_dat_o, e.dat);
               end
            end
            checks++;
            if (fault0 !== e.fault) begin
               errors++; $display("FAIL %s fault: got %b want %b", name, fault0, e.fault);
            end
            if (alt) begin
               checks++;
               if (bus1.m_err_o !== 1'b1 || bus1.m_ack_o !== 1'b0 || fault1 !== 1'b1) begin
                  errors++;
                  $display("FAIL %s default_err: got err=%b ack=%b fault=%b want err=1 ack=0 fault=1",
                           name, bus1.m_err_o, bus1.m_ack_o, fault1);
               end
            end
         end else begin
            checks++;
            if (fault0 !== 1'b0) begin
               errors++; $display("FAIL %s early_fault: got %b want 0 at cyc %0d", name, fault0, n);
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s no_response: got none within 40 cycles want ack/err", name);
         sb.delete();
      end
      if (!keep) begin
         @(posedge clk); #1;
         bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.s_cyc_o !== '0 || bus.s_stb_o !== '0) begin
         errors++; $display("FAIL reset_strobes: got cyc=%b stb=%b want 000", bus.s_cyc_o, bus.s_stb_o);
      end
      checks++;
      if (bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0 || fault0 !== 1'b0) begin
         errors++; $display("FAIL reset_resp: got ack=%b err=%b fault=%b want 0", bus.m_ack_o, bus.m_err_o, fault0);
      end
      checks++;
      if (bus.m_dat_o !== '0 || fadr0 !== '0) begin
         errors++; $display("FAIL reset_regs: got dat=%h fault_adr=%h want 0", bus.m_dat_o, fadr0);
      end
   endtask

   task automatic test_decode();
      xfer("rom_rd",   32'h0000_0000, 1'b0, 4'hF,    32'h0,         0, 1'b1, 1'b0, ROM_DAT,  1'b0, 2, 1'b0, 1'b0);
      xfer("ram_rd",   32'h0000_0010, 1'b0, 4'hF,    32'h0,         2, 1'b1, 1'b0, RAM_DAT,  1'b0, 2, 1'b0, 1'b0);
      xfer("tube_wr",  32'h0100_0004, 1'b1, 4'b0001, 32'h1122_3344, 1, 1'b1, 1'b0, TUBE_DAT, 1'b0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_default();
      xfer("def_rd", 32'h0200_0000, 1'b0, 4'hF, 32'h0, -1, 1'b1, 1'b0, DEF_DAT, 1'b0, 2, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (fadr1 !== 32'h0200_0000 || fadr0 !== 32'h0) begin
         errors++; $display("FAIL def_fault_adr: got err_sw=%h ack_sw=%h want 02000000 and 00000000", fadr1, fadr0);
      end
   endtask

   task automatic test_timeout();
      ram_stall = 1'b1;
      xfer("ram_tmo", 32'h0000_0020, 1'b0, 4'hF, 32'h0, 2, 1'b0, 1'b1, RAM_DAT, 1'b1, TMO + 1, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (fadr0 !== 32'h0000_0020) begin
         errors++; $display("FAIL tmo_fault_adr: got %h want 00000020", fadr0);
      end
      ram_stall = 1'b0;
      xfer("rom_after_tmo", 32'h0000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, ROM_DAT, 1'b0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_err_ack();
      tube_errmode = 1'b1;
      xfer("tube_errack", 32'h0100_0008, 1'b0, 4'hF, 32'h0, 1, 1'b0, 1'b1, TUBE_DAT, 1'b0, 4, 1'b0, 1'b0);
      tube_errmode = 1'b0;
   endtask

   task automatic test_abort();
      ram_stall = 1'b1;
      @(posedge clk); #1;
      bus.m_adr_i = 32'h0000_0010; bus.m_we_i = 1'b0; bus.m_sel_i = 4'hF;
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.s_stb_o !== 3'b100) begin
         errors++; $display("FAIL abort_busy1: got stb=%b want 100", bus.s_stb_o);
      end
      @(posedge clk); #1;
      bus.m_cyc_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.s_stb_o !== '0 || bus.s_cyc_o !== '0) begin
         errors++; $display("FAIL abort_strobe: got stb=%b cyc=%b want 000", bus.s_stb_o, bus.s_cyc_o);
      end
      checks++;
      if (bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0 || fault0 !== 1'b0) begin
         errors++; $display("FAIL abort_resp: got ack=%b err=%b fault=%b want 0", bus.m_ack_o, bus.m_err_o, fault0);
      end
      bus.m_stb_i = 1'b0;
      ram_stall = 1'b0;
      xfer("rom_after_abort", 32'h0000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, ROM_DAT, 1'b0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_reset_busy();
      ram_stall = 1'b1;
      @(posedge clk); #1;
      bus.m_adr_i = 32'h0000_0010; bus.m_we_i = 1'b0; bus.m_sel_i = 4'hF;
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.s_stb_o !== '0 || bus.s_cyc_o !== '0) begin
         errors++; $display("FAIL rst_busy_strobe: got stb=%b cyc=%b want 000", bus.s_stb_o, bus.s_cyc_o);
      end
      checks++;
      if (bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0 || fadr0 !== '0) begin
         errors++;
         $display("FAIL rst_busy_regs: got ack=%b err=%b fault_adr=%h want 0 0 0", bus.m_ack_o, bus.m_err_o, fadr0);
      end
      ram_stall = 1'b0;
      xfer("rom_after_rst", 32'h0000_0000, 1'b0, 4'hF, 32'h0, 0, 1'b1, 1'b0, ROM_DAT, 1'b0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      xfer("b2b_rom",  32'h0000_0000, 1'b0, 4'hF,    32'h0,         0, 1'b1, 1'b0, ROM_DAT,  1'b0, 2, 1'b1, 1'b0);
      xfer("b2b_ram",  32'h0000_0010, 1'b0, 4'hF,    32'h0,         2, 1'b1, 1'b0, RAM_DAT,  1'b0, 2, 1'b1, 1'b0);
      xfer("b2b_tube", 32'h0100_0000, 1'b1, 4'b1100, 32'hCAFE_F00D, 1, 1'b1, 1'b0, TUBE_DAT, 1'b0, 2, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ram_stall = 1'b0; tube_errmode = 1'b0;
      bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
      bus.m_we_i = 1'b0; bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      test_reset();
      test_decode();
      test_default();
      test_timeout();
      test_err_ack();
      test_abort();
      test_reset_busy();
      test_back_to_back();
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
